// File: rtl/queen_pkg.sv
// Shared types and constants for the parameterised N-queens solver.
// Defining QUEEN_CYC_CNT_EN adds the search cycle counter output (width CYC_CNT_W).
package queen_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    SEARCH = 3'd2,
    OUTPUT = 3'd3,
    FAIL   = 3'd4
  } state_t;

  localparam int DEF_N     = 12;
  localparam int DEF_W     = 4;
  localparam int CYC_CNT_W = 16;

endpackage

// File: rtl/queen_occupancy.sv
// Column and diagonal occupancy sets for the N-queens solver.
// One place or remove per cycle; test is combinational on the current contents.
module queen_occupancy
  import queen_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int W = DEF_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         place,
  input  logic         remove,
  input  logic [W-1:0] op_row,
  input  logic [W-1:0] op_col,
  input  logic [W-1:0] test_row,
  input  logic [W-1:0] test_col,
  output logic         free
);

  localparam int CW = $clog2(N);
  localparam int DW = $clog2(2*N-1);

  logic [N-1:0]   col_r;
  logic [2*N-2:0] diag_sum_r;
  logic [2*N-2:0] diag_dif_r;
  logic           test_in_range_s;

  function automatic logic [DW-1:0] sum_idx(input logic [W-1:0] r, input logic [W-1:0] c);
    return DW'({1'b0, r} + {1'b0, c});
  endfunction

  // r - c + N - 1, computed two bits wider so it never goes negative.
  function automatic logic [DW-1:0] dif_idx(input logic [W-1:0] r, input logic [W-1:0] c);
    return DW'({2'b00, r} + (W+2)'(N-1) - {2'b00, c});
  endfunction

  assign test_in_range_s = ({1'b0, test_row} < (W+1)'(N)) && ({1'b0, test_col} < (W+1)'(N));
  assign free = test_in_range_s
             && !col_r[CW'(test_col)]
             && !diag_sum_r[sum_idx(test_row, test_col)]
             && !diag_dif_r[dif_idx(test_row, test_col)];

  // Occupancy bits follow place/remove commands; reset or job start empties the board.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      col_r      <= '0;
      diag_sum_r <= '0;
      diag_dif_r <= '0;
    end else if (place) begin
      col_r[CW'(op_col)]                <= 1'b1;
      diag_sum_r[sum_idx(op_row, op_col)] <= 1'b1;
      diag_dif_r[dif_idx(op_row, op_col)] <= 1'b1;
    end else if (remove) begin
      col_r[CW'(op_col)]                <= 1'b0;
      diag_sum_r[sum_idx(op_row, op_col)] <= 1'b0;
      diag_dif_r[dif_idx(op_row, op_col)] <= 1'b0;
    end
  end

endmodule

// File: rtl/queen_solver_param.sv
// Row-ordered backtracking N-queens solver with optional preset queens.
// Optional feature: define QUEEN_CYC_CNT_EN to add the cyc_cnt search cycle counter.
module queen_solver_param
  import queen_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int W = DEF_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid_num,
  input  logic [W-1:0] in_num,
  input  logic         in_valid,
  input  logic [W-1:0] row,
  input  logic [W-1:0] col,
  output logic         out_valid,
  output logic [W-1:0] out,
  output logic         out_fail
`ifdef QUEEN_CYC_CNT_EN
  ,
  output logic [CYC_CNT_W-1:0] cyc_cnt
`endif
);

  localparam int RW = $clog2(N);

  state_t         state_r, state_nxt;
  logic [W-1:0]   k_r;
  logic [W-1:0]   load_cnt_r;
  logic           bad_r;
  logic [N-1:0]   preset_r;
  logic [W-1:0]   pos_r [N];
  logic [RW-1:0]  cur_row_r;
  logic [W:0]     cand_r;
  logic [RW-1:0]  out_idx_r;

  logic           occ_free_s;
  logic           place_s, remove_s, start_s;
  logic [W-1:0]   op_row_s, op_col_s, test_row_s, test_col_s;
  logic           adv_s, back_s, step_s;
  logic           load_rng_s, load_conf_s, load_last_s, bad_nxt_s;
  logic [N-1:0]   load_mask_s;
  logic           nxt_found_s, prv_found_s, first_found_s;
  logic [RW-1:0]  nxt_row_s, prv_row_s, first_row_s;

  assign load_rng_s  = ({1'b0, row} < (W+1)'(N)) && ({1'b0, col} < (W+1)'(N));
  assign load_conf_s = !load_rng_s || preset_r[RW'(row)] || !occ_free_s;
  assign load_last_s = in_valid && ((load_cnt_r + W'(1)) == k_r);
  assign bad_nxt_s   = bad_r || (in_valid && load_conf_s);
  assign load_mask_s = preset_r | (load_rng_s ? ((N)'(1) << RW'(row)) : '0);

  // Nearest non-preset rows on either side of the current row, and the first free row after loading.
  always_comb begin
    nxt_found_s   = 1'b0;
    nxt_row_s     = '0;
    prv_found_s   = 1'b0;
    prv_row_s     = '0;
    first_found_s = 1'b0;
    first_row_s   = '0;
    for (int i = N-1; i >= 0; i--) begin
      nxt_row_s     = ((i > int'(cur_row_r)) && !preset_r[i]) ? RW'(i) : nxt_row_s;
      nxt_found_s   = nxt_found_s | ((i > int'(cur_row_r)) && !preset_r[i]);
      first_row_s   = !load_mask_s[i] ? RW'(i) : first_row_s;
      first_found_s = first_found_s | !load_mask_s[i];
    end
    for (int i = 0; i < N; i++) begin
      prv_row_s   = ((i < int'(cur_row_r)) && !preset_r[i]) ? RW'(i) : prv_row_s;
      prv_found_s = prv_found_s | ((i < int'(cur_row_r)) && !preset_r[i]);
    end
  end

  // Next-state logic and occupancy commands.
  always_comb begin
    state_nxt  = state_r;
    place_s    = 1'b0;
    remove_s   = 1'b0;
    start_s    = 1'b0;
    adv_s      = 1'b0;
    back_s     = 1'b0;
    step_s     = 1'b0;
    op_row_s   = '0;
    op_col_s   = '0;
    test_row_s = '0;
    test_col_s = '0;
    case (state_r)
      IDLE: begin
        if (in_valid_num) begin
          start_s   = 1'b1;
          state_nxt = (in_num != '0) ? LOAD : SEARCH;
        end else begin
          state_nxt = IDLE;
        end
      end
      LOAD: begin
        test_row_s = row;
        test_col_s = col;
        if (in_valid) begin
          place_s  = !load_conf_s;
          op_row_s = row;
          op_col_s = col;
          if (load_last_s) begin
            state_nxt = (bad_nxt_s || !first_found_s) ? FAIL : SEARCH;
          end else begin
            state_nxt = LOAD;
          end
        end else begin
          state_nxt = LOAD;
        end
      end
      SEARCH: begin
        test_row_s = W'(cur_row_r);
        test_col_s = cand_r[W-1:0];
        if (cand_r == (W+1)'(N)) begin
          // Row exhausted: lift the queen from the previous free row and retry it one column on.
          if (prv_found_s) begin
            back_s    = 1'b1;
            remove_s  = 1'b1;
            op_row_s  = W'(prv_row_s);
            op_col_s  = pos_r[prv_row_s];
            state_nxt = SEARCH;
          end else begin
            state_nxt = FAIL;
          end
        end else if (occ_free_s) begin
          adv_s     = 1'b1;
          place_s   = 1'b1;
          op_row_s  = W'(cur_row_r);
          op_col_s  = cand_r[W-1:0];
          state_nxt = nxt_found_s ? SEARCH : OUTPUT;
        end else begin
          step_s    = 1'b1;
          state_nxt = SEARCH;
        end
      end
      OUTPUT: begin
        state_nxt = (out_idx_r == RW'(N-1)) ? IDLE : OUTPUT;
      end
      FAIL: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  queen_occupancy #(.N(N), .W(W)) u_occ (
    .clk      (clk),
    .rst      (rst),
    .clr      (start_s),
    .place    (place_s),
    .remove   (remove_s),
    .op_row   (op_row_s),
    .op_col   (op_col_s),
    .test_row (test_row_s),
    .test_col (test_col_s),
    .free     (occ_free_s)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt;
    end
  end

  // Job bookkeeping: preset loading, row stack of placed columns, search cursor, output index.
  always_ff @(posedge clk) begin
    if (rst) begin
      k_r        <= '0;
      load_cnt_r <= '0;
      bad_r      <= 1'b0;
      preset_r   <= '0;
      cur_row_r  <= '0;
      cand_r     <= '0;
      out_idx_r  <= '0;
      for (int i = 0; i < N; i++) begin
        pos_r[i] <= '0;
      end
    end else if (start_s) begin
      k_r        <= in_num;
      load_cnt_r <= '0;
      bad_r      <= 1'b0;
      preset_r   <= '0;
      cur_row_r  <= '0;
      cand_r     <= '0;
      out_idx_r  <= '0;
    end else if ((state_r == LOAD) && in_valid) begin
      load_cnt_r <= load_cnt_r + W'(1);
      bad_r      <= bad_nxt_s;
      if (load_rng_s) begin
        preset_r[RW'(row)] <= 1'b1;
        pos_r[RW'(row)]    <= col;
      end
      if (load_last_s) begin
        cur_row_r <= first_row_s;
        cand_r    <= '0;
      end
    end else if (adv_s) begin
      pos_r[cur_row_r] <= cand_r[W-1:0];
      cur_row_r        <= nxt_row_s;
      cand_r           <= '0;
    end else if (back_s) begin
      cur_row_r <= prv_row_s;
      cand_r    <= {1'b0, pos_r[prv_row_s]} + (W+1)'(1);
    end else if (step_s) begin
      cand_r <= cand_r + (W+1)'(1);
    end else if (state_r == OUTPUT) begin
      out_idx_r <= out_idx_r + RW'(1);
    end
  end

  // Registered result beats; everything reads zero between beats.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out       <= '0;
      out_fail  <= 1'b0;
    end else begin
      out_valid <= (state_r == OUTPUT) || (state_r == FAIL);
      out       <= (state_r == OUTPUT) ? pos_r[out_idx_r] : '0;
      out_fail  <= (state_r == FAIL);
    end
  end

`ifdef QUEEN_CYC_CNT_EN
  // Saturating count of SEARCH cycles for the current job.
  always_ff @(posedge clk) begin
    if (rst || start_s) begin
      cyc_cnt <= '0;
    end else if ((state_r == SEARCH) && (cyc_cnt != {CYC_CNT_W{1'b1}})) begin
      cyc_cnt <= cyc_cnt + CYC_CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_queen_solver_param.sv
// Scoreboard bench for queen_solver_param with N=4, 8 and 12 instances.
// With QUEEN_CYC_CNT_EN defined it also checks cyc_cnt on the bad-preset job.
module tb_queen_solver_param;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ivn  [3];
  logic [3:0] inum [3];
  logic       iv   [3];
  logic [3:0] rowa [3];
  logic [3:0] cola [3];
  logic       ov   [3];
  logic [3:0] o    [3];
  logic       of   [3];
`ifdef QUEEN_CYC_CNT_EN
  logic [15:0] cyc [3];
`endif

  logic [4:0] q0 [$];
  logic [4:0] q1 [$];
  logic [4:0] q2 [$];
  int tests = 0;
  int fails = 0;
  logic mon_en = 1'b0;

  logic [3:0] seq4a  [4]  = '{4'd1, 4'd3, 4'd0, 4'd2};
  logic [3:0] seq4b  [4]  = '{4'd2, 4'd0, 4'd3, 4'd1};
  logic [3:0] seq8   [8]  = '{4'd0, 4'd4, 4'd7, 4'd5, 4'd2, 4'd6, 4'd1, 4'd3};
  logic [3:0] seq12  [12] = '{4'd0, 4'd2, 4'd4, 4'd7, 4'd9, 4'd11, 4'd5, 4'd10, 4'd1, 4'd6, 4'd8, 4'd3};

  always #5 clk = ~clk;

  queen_solver_param #(.N(4), .W(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid_num(ivn[0]), .in_num(inum[0]), .in_valid(iv[0]),
    .row(rowa[0]), .col(cola[0]), .out_valid(ov[0]), .out(o[0]), .out_fail(of[0])
`ifdef QUEEN_CYC_CNT_EN
    , .cyc_cnt(cyc[0])
`endif
  );

  queen_solver_param #(.N(8), .W(4)) dut8 (
    .clk(clk), .rst(rst), .in_valid_num(ivn[1]), .in_num(inum[1]), .in_valid(iv[1]),
    .row(rowa[1]), .col(cola[1]), .out_valid(ov[1]), .out(o[1]), .out_fail(of[1])
`ifdef QUEEN_CYC_CNT_EN
    , .cyc_cnt(cyc[1])
`endif
  );

  queen_solver_param #(.N(12), .W(4)) dut12 (
    .clk(clk), .rst(rst), .in_valid_num(ivn[2]), .in_num(inum[2]), .in_valid(iv[2]),
    .row(rowa[2]), .col(cola[2]), .out_valid(ov[2]), .out(o[2]), .out_fail(of[2])
`ifdef QUEEN_CYC_CNT_EN
    , .cyc_cnt(cyc[2])
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int idx, input logic [4:0] v);
    case (idx)
      0: q0.push_back(v);
      1: q1.push_back(v);
      default: q2.push_back(v);
    endcase
  endtask

  task automatic start(input int idx, input logic [3:0] k);
    ivn[idx]  = 1'b1;
    inum[idx] = k;
    tick();
    ivn[idx]  = 1'b0;
    inum[idx] = 4'd0;
  endtask

  task automatic preset(input int idx, input logic [3:0] r, input logic [3:0] c, input int gap);
    iv[idx]   = 1'b1;
    rowa[idx] = r;
    cola[idx] = c;
    tick();
    iv[idx]   = 1'b0;
    rowa[idx] = 4'd0;
    cola[idx] = 4'd0;
    repeat (gap) tick();
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((q0.size() + q1.size() + q2.size()) != 0 && n < 20000) begin
      tick();
      n++;
    end
    tests++;
    if ((q0.size() + q1.size() + q2.size()) != 0) begin
      fails++;
      $display("FAIL %s: timeout with %0d beats outstanding, required 0",
               name, q0.size() + q1.size() + q2.size());
      q0.delete();
      q1.delete();
      q2.delete();
    end
    repeat (4) tick();
  endtask

  task automatic mon(input int idx, input logic v, input logic [3:0] ob, input logic fb);
    logic [4:0] e = 5'd0;
    logic have = 1'b0;
    tests++;
    if (v) begin
      case (idx)
        0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
        1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
        default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
      endcase
      if (!have) begin
        fails++;
        $display("FAIL beat_dut%0d: unexpected beat out=%0d fail=%0b, required no beat", idx, ob, fb);
      end else if ({fb, ob} !== e) begin
        fails++;
        $display("FAIL beat_dut%0d: got out=%0d fail=%0b, required out=%0d fail=%0b",
                 idx, ob, fb, e[3:0], e[4]);
      end
    end else if (ob !== 4'd0 || fb !== 1'b0) begin
      fails++;
      $display("FAIL idle_dut%0d: got out=%0d fail=%0b, required 0/0", idx, ob, fb);
    end
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      mon(0, ov[0], o[0], of[0]);
      mon(1, ov[1], o[1], of[1]);
      mon(2, ov[2], o[2], of[2]);
    end
  end

  initial begin
    int n;
    for (int i = 0; i < 3; i++) begin
      ivn[i] = 1'b0; inum[i] = 4'd0; iv[i] = 1'b0; rowa[i] = 4'd0; cola[i] = 4'd0;
    end
    repeat (3) tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (ov[i] !== 1'b0 || o[i] !== 4'd0 || of[i] !== 1'b0) begin
        fails++;
        $display("FAIL reset_dut%0d: got valid=%0b out=%0d fail=%0b, required 0/0/0", i, ov[i], o[i], of[i]);
      end
    end
    mon_en = 1'b1;

    foreach (seq4a[i]) push(0, {1'b0, seq4a[i]});
    start(0, 4'd0);
    drain("n4_k0");

    // Job starts and presets sent mid-search must be ignored.
    foreach (seq8[i]) push(1, {1'b0, seq8[i]});
    start(1, 4'd0);
    repeat (5) tick();
    ivn[1] = 1'b1; inum[1] = 4'd2; iv[1] = 1'b1; rowa[1] = 4'd0; cola[1] = 4'd3;
    tick();
    ivn[1] = 1'b0; inum[1] = 4'd0; iv[1] = 1'b0; cola[1] = 4'd0;
    drain("n8_k0");

    foreach (seq4b[i]) push(0, {1'b0, seq4b[i]});
    start(0, 4'd1);
    preset(0, 4'd0, 4'd2, 0);
    drain("n4_p02");

    push(0, 5'b1_0000);
    start(0, 4'd1);
    preset(0, 4'd0, 4'd0, 0);
    drain("n4_p00_fail");

    foreach (seq4a[i]) push(0, {1'b0, seq4a[i]});
    start(0, 4'd2);
    repeat (2) tick();
    preset(0, 4'd2, 4'd0, 3);
    preset(0, 4'd0, 4'd1, 0);
    drain("n4_two_presets_gaps");

    push(0, 5'b1_0000);
    start(0, 4'd1);
    preset(0, 4'd0, 4'd5, 0);
    drain("n4_col_range");

    push(0, 5'b1_0000);
    start(0, 4'd2);
    preset(0, 4'd1, 4'd3, 0);
    preset(0, 4'd4, 4'd0, 0);
    drain("n4_row_range");

    push(0, 5'b1_0000);
    start(0, 4'd2);
    preset(0, 4'd1, 4'd0, 0);
    preset(0, 4'd1, 4'd2, 0);
    drain("n4_same_row");

    push(2, 5'b1_0000);
    start(2, 4'd2);
    preset(2, 4'd0, 4'd0, 0);
    preset(2, 4'd1, 4'd1, 0);
    n = 0;
    while (!ov[2] && n < 50) begin
      tick();
      n++;
    end
    tests++;
    if (!ov[2]) begin
      fails++;
      $display("FAIL n12_diag_fail_beat: no beat after %0d cycles, required a fail beat", n);
    end
`ifdef QUEEN_CYC_CNT_EN
    else if (cyc[2] !== 16'd0) begin
      fails++;
      $display("FAIL n12_diag_cyc_cnt: got %0d, required 0", cyc[2]);
    end
`endif
    drain("n12_diag_fail");

    // Abort a job mid-search; nothing from it may appear afterwards.
    start(2, 4'd0);
    repeat (40) tick();
    rst = 1'b1;
    tick();
    tests++;
    if (ov[2] !== 1'b0 || o[2] !== 4'd0 || of[2] !== 1'b0) begin
      fails++;
      $display("FAIL n12_abort_reset: got valid=%0b out=%0d fail=%0b, required 0/0/0", ov[2], o[2], of[2]);
    end
    rst = 1'b0;
    repeat (30) tick();
    foreach (seq12[i]) push(2, {1'b0, seq12[i]});
    start(2, 4'd0);
    drain("n12_after_abort");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
